irq_trigger_gen: RTL

IRQ_TRIGGER_GEN -- requirements
Module: irq_trigger_gen

---
 rtl/irq_trig_pkg.sv | 29 ++
 rtl/irq_trig_match.sv | 28 ++
 rtl/irq_trigger_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/irq_trig_pkg.sv
// rtl/irq_trig_pkg.sv - shared types and defaults for the address-triggered IRQ generator
package irq_trig_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int N_ENTRIES_DEF = 32;
  localparam int N_CH_DEF      = 6;
  localparam int CNT_W_DEF     = 8;

  // Select-field width that stays legal for a single-element range.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2
  } trig_state_t;

  // Trigger entry in the default configuration.
  typedef struct packed {
    logic                        armed;
    logic [ADDR_W_DEF-1:0]       addr;
    logic [CNT_W_DEF-1:0]        delay;
    logic [CNT_W_DEF-1:0]        width;
    logic [sel_w(N_CH_DEF)-1:0]  ch;
  } trig_entry_t;

endpackage

// File: rtl/irq_trig_match.sv
// rtl/irq_trig_match.sv - parallel address compare of all armed entries, lowest index wins
module irq_trig_match
  import irq_trig_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int N_ENTRIES = N_ENTRIES_DEF,
  parameter int IDX_W     = sel_w(N_ENTRIES_DEF)
) (
  input  logic [N_ENTRIES-1:0] i_armed,
  input  logic [ADDR_W-1:0]    i_tab_addr [N_ENTRIES],
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_idx
);

  // Scanning downward lets the lowest matching index overwrite the rest.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (i_armed[i] && (i_tab_addr[i] == i_addr)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_trigger_gen.sv
// rtl/irq_trigger_gen.sv - address-match trigger table driving delayed, timed IRQ pulses
// IRQ_TRIG_ACK_EN adds the irq_ack input that ends an assertion early.
module irq_trigger_gen
  import irq_trig_pkg::*;
#(
  parameter int  ADDR_W    = ADDR_W_DEF,
  parameter int  N_ENTRIES = N_ENTRIES_DEF,
  parameter int  N_CH      = N_CH_DEF,
  parameter int  CNT_W     = CNT_W_DEF,
  localparam int IDX_W     = sel_w(N_ENTRIES),
  localparam int CH_W      = sel_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_arm,
`ifdef IRQ_TRIG_ACK_EN
  input  logic              irq_ack,
`endif
  output logic [N_CH-1:0]   irq,
  output logic              busy,
  output logic              fire_pulse,
  output logic [IDX_W-1:0]  fire_idx
);

  logic [N_ENTRIES-1:0] r_armed;
  logic [ADDR_W-1:0]    r_tab_addr  [N_ENTRIES];
  logic [CNT_W-1:0]     r_tab_delay [N_ENTRIES];
  logic [CNT_W-1:0]     r_tab_width [N_ENTRIES];
  logic [CH_W-1:0]      r_tab_ch    [N_ENTRIES];

  trig_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_width;
  logic [CH_W-1:0]      r_ch;
  logic [N_CH-1:0]      r_irq;
  logic                 r_fire_pulse;
  logic [IDX_W-1:0]     r_fire_idx;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_ack;
  logic                 w_cfg_ok;
  logic [CH_W-1:0]      w_ch_sel;
  logic [N_CH-1:0]      w_ch_onehot;

`ifdef IRQ_TRIG_ACK_EN
  assign w_ack = irq_ack;
`else
  assign w_ack = 1'b0;
`endif

  assign w_cfg_ok = cfg_we && (int'(cfg_idx) < N_ENTRIES);

  irq_trig_match #(
    .ADDR_W    (ADDR_W),
    .N_ENTRIES (N_ENTRIES),
    .IDX_W     (IDX_W)
  ) u_match (
    .i_armed    (r_armed),
    .i_tab_addr (r_tab_addr),
    .i_addr     (addr),
    .o_hit      (w_hit),
    .o_idx      (w_idx)
  );

  // Zero-delay triggers raise irq straight from the table; delayed ones use the latched channel.
  assign w_ch_sel = (r_state == ST_IDLE) ? r_tab_ch[w_idx] : r_ch;

  always_comb begin
    w_ch_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ch_onehot[i] = (w_ch_sel == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (w_cfg_ok) begin
      r_tab_addr[cfg_idx]  <= cfg_addr;
      r_tab_delay[cfg_idx] <= cfg_delay;
      r_tab_width[cfg_idx] <= cfg_width;
      r_tab_ch[cfg_idx]    <= cfg_ch;
    end
  end

  always_ff @(posedge clk) begin
    r_fire_pulse <= 1'b0;
    if (reset) begin
      r_state    <= ST_IDLE;
      r_irq      <= '0;
      r_cnt      <= '0;
      r_width    <= '0;
      r_ch       <= '0;
      r_fire_idx <= '0;
      r_armed    <= '0;
    end else begin
      if (!en) begin
        r_state <= ST_IDLE;
        r_irq   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_hit) begin
              r_armed[w_idx] <= 1'b0;
              r_fire_pulse   <= 1'b1;
              r_fire_idx     <= w_idx;
              r_width        <= r_tab_width[w_idx];
              r_ch           <= r_tab_ch[w_idx];
              if (r_tab_delay[w_idx] == '0) begin
                r_state <= ST_ASSERT;
                r_irq   <= w_ch_onehot;
                r_cnt   <= r_tab_width[w_idx];
              end else begin
                r_state <= ST_WAIT;
                r_cnt   <= r_tab_delay[w_idx];
              end
            end
          end
          ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_ASSERT;
              r_irq   <= w_ch_onehot;
              r_cnt   <= r_width;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_ASSERT: begin
            if (w_ack || (r_cnt == '0)) begin
              r_state <= ST_IDLE;
              r_irq   <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_irq   <= '0;
          end
        endcase
      end
      // A table write lands after any same-edge disarm, so cfg_arm is what sticks.
      if (w_cfg_ok) begin
        r_armed[cfg_idx] <= cfg_arm;
      end
    end
  end

  assign irq        = r_irq;
  assign busy       = (r_state != ST_IDLE);
  assign fire_pulse = r_fire_pulse;
  assign fire_idx   = r_fire_idx;

endmodule
